pipe_stall_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage core. Merges the ID-stage hazard stall request, the EX-stage control-flow redirect and the MEM-stage data-memory handshake into one consistent set of write-enable and flush strobes. Those strobes drive the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also tracks stall duration and flags runaway stalls through a watchdog.

---
 rtl/pipe_stall_ctrl.sv | 106 ++++++++++
 tb/tb_pipe_stall_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: merges hazard stall, EX redirect and dmem handshake into
// write-enable/flush strobes. Optional perf counters under PIPE_PERF_CNT_EN.
module pipe_stall_ctrl #(
  parameter int MAX_STALL = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req,
  input  logic        redirect,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        id_ex_we,
  output logic        ex_mem_we,
  output logic        mem_wb_we,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic [1:0]  ctrl_state,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);
  typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, MEMWAIT = 2'd2} state_t;

  localparam int CW = $clog2(MAX_STALL + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STALL);

  state_t        state, state_nxt;
  logic [CW-1:0] hold_cnt;
  logic          freeze;

  assign freeze     = dmem_req & ~dmem_ready;
  assign ctrl_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Same decode in every state; state only records last cycle's stall cause.
  always_comb begin
    state_nxt   = RUN;
    pc_we       = 1'b1;
    if_id_we    = 1'b1;
    id_ex_we    = 1'b1;
    ex_mem_we   = 1'b1;
    mem_wb_we   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (freeze) begin
      state_nxt = MEMWAIT;
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      mem_wb_we = 1'b0;
    end else if (redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (stall_req) begin
      state_nxt   = HOLD;
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
    end
    if (rst) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_we    = 1'b0;
      ex_mem_we   = 1'b0;
      mem_wb_we   = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
    end
  end

  // Watchdog: run length of consecutive stalled cycles, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt      <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (state_nxt == RUN)       hold_cnt <= '0;
      else if (hold_cnt != CNT_MAX) hold_cnt <= hold_cnt + 1'b1;
      if (hold_cnt == CNT_MAX)    stall_timeout <= 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // flush_count counts redirects when actually taken (not while frozen).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_we)       stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush)  flush_count  <= flush_count + 32'd1;
    end
  end
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed steps plus random traffic
// against a cycle-level reference model.
module tb_pipe_stall_ctrl;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_req = 0, redirect = 0, dmem_req = 0, dmem_ready = 0;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        if_id_flush, id_ex_flush, stall_timeout;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cycles, flush_count;

  int tests = 0, fails = 0;

  // reference model state
  int          m_state = 0;
  int          m_run = 0;
  bit          m_to = 0;
  logic [31:0] m_stall = 0, m_flush = 0;

  pipe_stall_ctrl #(.MAX_STALL(MAXS)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .redirect(redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ctrl_state(ctrl_state), .stall_timeout(stall_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush};
  endfunction

  // Expected strobes from the stage-advance rules: back end moves unless the
  // memory is stalling; front end also holds on an unredirected hazard.
  function automatic logic [6:0] exp_strobes(bit r, bit sr, bit rd, bit dq, bit dr);
    bit frz, back, front;
    if (r) return 7'b0;
    frz   = dq && !dr;
    back  = !frz;
    front = !frz && (rd || !sr);
    return {front, front, back, back, back, !frz && rd, !frz && (rd || sr)};
  endfunction

  function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef PIPE_PERF_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0; m_run = 0; m_to = 0; m_stall = 0; m_flush = 0;
  endtask

  // One cycle: drive at negedge, check strobes, clock, check registered state.
  task automatic cyc(input bit sr, input bit rd, input bit dq, input bit dr, input string tag);
    bit frz, hz;
    stall_req = sr; redirect = rd; dmem_req = dq; dmem_ready = dr;
    #1;
    chk({tag, ".strobes"}, 32'(strobes()), 32'(exp_strobes(rst, sr, rd, dq, dr)));
    frz = dq && !dr;
    hz  = !frz && !rd && sr;
    @(posedge clk);
    if (!rst) begin
      if (m_run >= MAXS) m_to = 1;
      m_run   = (frz || hz) ? m_run + 1 : 0;
      m_state = frz ? 2 : (hz ? 1 : 0);
      if (frz || hz)  m_stall = m_stall + 32'd1;
      if (!frz && rd) m_flush = m_flush + 32'd1;
    end
    #1;
    chk({tag, ".state"},   32'(ctrl_state),    32'(m_state));
    chk({tag, ".timeout"}, 32'(stall_timeout), 32'(m_to));
    chk({tag, ".stall_cycles"}, stall_cycles, exp_cnt(m_stall));
    chk({tag, ".flush_count"},  flush_count,  exp_cnt(m_flush));
    @(negedge clk);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst.strobes", 32'(strobes()), 32'd0);
    chk("rst.state", 32'(ctrl_state), 32'd0);
    chk("rst.timeout", 32'(stall_timeout), 32'd0);
    chk("rst.stall_cycles", stall_cycles, 32'd0);
    chk("rst.flush_count", flush_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // idle: everything advances
    cyc(0, 0, 0, 0, "idle");
    chk("idle.pc_we", 32'(pc_we), 32'd1);

    // two-cycle load-use hazard
    cyc(1, 0, 0, 0, "haz1");
    chk("haz1.state_hold", 32'(ctrl_state), 32'd1);
    cyc(1, 0, 0, 0, "haz2");
    cyc(0, 0, 0, 0, "haz_done");
    chk("haz_done.state_run", 32'(ctrl_state), 32'd0);

    // three frozen cycles then ready
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, "frz");
    chk("frz.state_memwait", 32'(ctrl_state), 32'd2);
    cyc(0, 0, 1, 1, "frz_ready");
    chk("frz_ready.state_run", 32'(ctrl_state), 32'd0);

    // redirect overrides hazard
    cyc(1, 1, 0, 0, "redir_haz");
    chk("redir_haz.state_run", 32'(ctrl_state), 32'd0);

    // redirect held during freeze, taken on ready; ready without req ignored
    cyc(0, 1, 1, 0, "redir_frz");
    cyc(0, 1, 1, 1, "redir_ready");
    cyc(1, 0, 0, 1, "ready_noreq");

    // random traffic
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), "rand");

    // clean watchdog run via reset, then six frozen cycles
    rst = 1'b1; #1; model_reset(); @(negedge clk); rst = 1'b0;
    chk("wd.timeout_clear", 32'(stall_timeout), 32'd0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, "wd_frz");
    chk("wd.timeout_set", 32'(stall_timeout), 32'd1);
    cyc(0, 0, 1, 1, "wd_ready");
    cyc(0, 0, 0, 0, "wd_idle");
    chk("wd.timeout_sticky", 32'(stall_timeout), 32'd1);

    // reset asserted mid-MEMWAIT
    cyc(0, 0, 1, 0, "mw1");
    cyc(0, 0, 1, 0, "mw2");
    rst = 1'b1;
    #1;
    chk("mwrst.state", 32'(ctrl_state), 32'd0);
    chk("mwrst.timeout", 32'(stall_timeout), 32'd0);
    chk("mwrst.strobes", 32'(strobes()), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0, 0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
